// File: rtl/dmem_arbiter.sv
// dmem_arbiter: N-requester access arbiter in front of a single-port data memory.
// Grants one requester per cycle, either a forced select (mode=0) or round-robin
// with burst hold (mode=1). The accepted access is registered onto the mem_* port,
// and read data returns to the owning requester as a one-hot rvalid strobe.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   mode, force_sel      0 = forced select of force_sel, 1 = round-robin
//   req, we              per-requester request (held until gnt) and write enable
//   addr, wdata          packed per-requester address / write data (i at [i*W +: W])
//   gnt                  one-hot grant, combinational from req and arbiter state
//   rvalid, rdata        one-hot read-return strobe and its data
//   mem_en/we/addr/wdata registered memory command
//   mem_rdata            memory read data, RD_LAT cycles after mem_en
module dmem_arbiter #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mode,
    input  logic [$clog2(N_REQ)-1:0]   force_sel,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ-1:0]           we,
    input  logic [N_REQ*ADDR_W-1:0]    addr,
    input  logic [N_REQ*DATA_W-1:0]    wdata,
    output logic [N_REQ-1:0]           gnt,
    output logic [N_REQ-1:0]           rvalid,
    output logic [DATA_W-1:0]          rdata,
    output logic                       mem_en,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [DATA_W-1:0]          mem_rdata
);

    localparam int unsigned SEL_W = $clog2(N_REQ);
    localparam int unsigned NSEL  = 1 << SEL_W;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t             state;
    logic [SEL_W-1:0]   owner;
    logic [SEL_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]   count;
    logic               mode_q;
    logic [SEL_W-1:0]   fsel_q;

    // Read-return pipe: stages 0..RD_LAT-1 here, final stage is the rvalid register.
    logic [RD_LAT-1:0]  pv;
    logic [SEL_W-1:0]   pidx [RD_LAT];

    logic               chg;
    logic               own_act;
    logic [SEL_W-1:0]   start;
    int unsigned        span;
    logic [N_REQ-1:0]   owner_oh;
    logic               others;
    logic [NSEL-1:0]    req_ext;
    logic [NSEL-1:0]    we_ext;
    logic [NSEL-1:0]    sel_ok;
    logic               sel_v;
    logic [SEL_W-1:0]   sel_idx;
    logic               hold;
    logic               gnt_any;
    logic [SEL_W-1:0]   gnt_idx;
    logic               push;

    function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] x);
        if (32'(x) == N_REQ - 1) return '0;
        return x + SEL_W'(1);
    endfunction

    function automatic logic [SEL_W-1:0] idx_add(input logic [SEL_W-1:0] base,
                                                 input int unsigned k);
        int unsigned s;
        s = 32'(base) + k;
        if (s >= N_REQ) s = s - N_REQ;
        return SEL_W'(s);
    endfunction

    // Grant selection for both modes.
    always_comb begin
        chg      = (mode != mode_q) || (force_sel != fsel_q);
        // A mode or force_sel change ends the burst in the same cycle.
        own_act  = (state == OWN) && !chg;
        // Search origin: one past the owner when leaving it, else the rr pointer.
        start    = (state == OWN) ? wrap_inc(owner) : rr_ptr;
        span     = own_act ? N_REQ - 1 : N_REQ;
        req_ext  = NSEL'(req);
        we_ext   = NSEL'(we);
        owner_oh = '0;
        sel_ok   = '0;
        sel_v    = 1'b0;
        sel_idx  = '0;
        hold     = 1'b0;
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        gnt      = '0;

        for (int unsigned i = 0; i < N_REQ; i++) begin
            owner_oh[i] = (32'(owner) == i);
        end
        for (int unsigned i = 0; i < NSEL; i++) begin
            sel_ok[i] = (i < N_REQ);
        end
        others = |(req & ~owner_oh);

        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (!sel_v && (k < span) && req_ext[idx_add(start, k)]) begin
                sel_v   = 1'b1;
                sel_idx = idx_add(start, k);
            end
        end

        hold = mode && own_act && req_ext[owner] && ((count < BURST_MAX) || !others);

        if (mode) begin
            if (hold) begin
                gnt_any = 1'b1;
                gnt_idx = owner;
            end else if (sel_v) begin
                gnt_any = 1'b1;
                gnt_idx = sel_idx;
            end
        end else if (sel_ok[force_sel] && req_ext[force_sel]) begin
            gnt_any = 1'b1;
            gnt_idx = force_sel;
        end

        if (rst) gnt_any = 1'b0;

        for (int unsigned i = 0; i < N_REQ; i++) begin
            gnt[i] = gnt_any && (32'(gnt_idx) == i);
        end

        push = gnt_any && !we_ext[gnt_idx];
    end

    // Round-robin FSM: owner, burst count and rotation pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
            count  <= '0;
            mode_q <= 1'b0;
            fsel_q <= '0;
        end else begin
            mode_q <= mode;
            fsel_q <= force_sel;
            if ((state == OWN) && !hold) rr_ptr <= wrap_inc(owner);
            if (!mode) begin
                state <= IDLE;
                count <= '0;
            end else if (hold) begin
                if (count < BURST_MAX) count <= count + CNT_W'(1);
            end else if (sel_v) begin
                state <= OWN;
                owner <= sel_idx;
                count <= CNT_W'(1);
            end else begin
                state <= IDLE;
                count <= '0;
            end
        end
    end

    // Memory command register; address and data hold when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (gnt_any) begin
            mem_en    <= 1'b1;
            mem_we    <= we_ext[gnt_idx];
            mem_addr  <= addr[32'(gnt_idx)*ADDR_W +: ADDR_W];
            mem_wdata <= wdata[32'(gnt_idx)*DATA_W +: DATA_W];
        end else begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
        end
    end

    // Read-return tag pipe, RD_LAT+1 stages from grant to rvalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pv     <= '0;
            rvalid <= '0;
            for (int unsigned k = 0; k < RD_LAT; k++) pidx[k] <= '0;
        end else begin
            pv[0]   <= push;
            pidx[0] <= gnt_idx;
            for (int unsigned k = 1; k < RD_LAT; k++) begin
                pv[k]   <= pv[k-1];
                pidx[k] <= pidx[k-1];
            end
            for (int unsigned i = 0; i < N_REQ; i++) begin
                rvalid[i] <= pv[RD_LAT-1] && (32'(pidx[RD_LAT-1]) == i);
            end
        end
    end

    // Read data is the memory output in the rvalid cycle, zero otherwise.
    assign rdata = (|rvalid) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a delayed-read memory model.
module tb_dmem_arbiter;
    localparam int unsigned N  = 4;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam int unsigned RL = 2;
    localparam int unsigned MB = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            mode;
    logic [1:0]      force_sel;
    logic [N-1:0]    req;
    logic [N-1:0]    we;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rvalid;
    logic [DW-1:0]   rdata;
    logic            mem_en;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;

    dmem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .N_REQ(N), .RD_LAT(RL), .MAX_BURST(MB)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .force_sel(force_sel),
        .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: data in cycle c is a function of mem_addr from cycle c-RL.
    logic [AW-1:0] hist [RL];
    always @(posedge clk) begin
        hist[0] <= mem_addr;
        for (int k = 1; k < RL; k++) hist[k] <= hist[k-1];
    end
    assign mem_rdata = hist[RL-1] ^ 16'hBEEF;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic       mode;
        logic [1:0] fsel;
        logic [3:0] req;
        logic [3:0] exp_gnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic m, input logic [1:0] f, input logic [3:0] r,
                       input logic [3:0] g, input int n);
        vec_t v;
        v.mode = m; v.fsel = f; v.req = r; v.exp_gnt = g;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        addr[i*AW +: AW] = a;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] prev;
        int         pidx;

        rst = 1'b1; mode = 1'b0; force_sel = 2'd0; req = '0; we = '0;
        addr = '0; wdata = '0;
        tick(); tick();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_rvalid", 32'(rvalid), 32'h0);
        check("rst_rdata", 32'(rdata), 32'h0);
        check("rst_mem_en", 32'(mem_en), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        rst = 1'b0;
        tick();

        // Forced select of requester 2 with everyone requesting.
        for (int i = 0; i < 4; i++) set_addr(i, AW'(16'h0010 + i));
        set_addr(2, 16'h0040);
        mode = 1'b0; force_sel = 2'd2; req = 4'b1111; we = 4'b0000;
        #1 check("forced_gnt", 32'(gnt), 32'h4);
        tick();
        req = 4'b0000;
        #1 check("forced_mem_en", 32'(mem_en), 32'h1);
        check("forced_mem_addr", 32'(mem_addr), 32'h0040);
        check("forced_mem_we", 32'(mem_we), 32'h0);
        tick();
        #1 check("forced_idle_en", 32'(mem_en), 32'h0);
        check("forced_addr_hold", 32'(mem_addr), 32'h0040);
        tick();
        #1 check("forced_rvalid", 32'(rvalid), 32'h4);
        check("forced_rdata", 32'(rdata), 32'(16'h0040 ^ 16'hBEEF));
        tick();

        // Vector table: forced cases, RR burst rotation, lone requester.
        add(1'b0, 2'd1, 4'b1010, 4'b0010, 1);
        add(1'b0, 2'd0, 4'b1110, 4'b0000, 1);
        add(1'b0, 2'd3, 4'b1000, 4'b1000, 1);
        add(1'b0, 2'd2, 4'b1111, 4'b0100, 1);
        add(1'b0, 2'd2, 4'b0000, 4'b0000, 1);
        add(1'b1, 2'd2, 4'b1011, 4'b0001, 4);
        add(1'b1, 2'd2, 4'b1011, 4'b0010, 4);
        add(1'b1, 2'd2, 4'b1011, 4'b1000, 4);
        add(1'b1, 2'd2, 4'b1011, 4'b0001, 1);
        add(1'b1, 2'd2, 4'b1000, 4'b1000, 10);
        add(1'b1, 2'd2, 4'b0000, 4'b0000, 1);

        for (int i = 0; i < 4; i++) begin
            set_addr(i, AW'(16'h0100 + i));
            wdata[i*DW +: DW] = DW'(16'hA000 + i);
        end
        we = 4'b1111;
        prev = 4'b0000;
        foreach (vecs[n]) begin
            mode = vecs[n].mode; force_sel = vecs[n].fsel; req = vecs[n].req;
            #1;
            check($sformatf("vec%0d_gnt", n), 32'(gnt), 32'(vecs[n].exp_gnt));
            check($sformatf("vec%0d_mem_en", n), 32'(mem_en), 32'(prev != 4'b0000));
            if (prev != 4'b0000) begin
                pidx = 0;
                for (int b = 0; b < 4; b++) if (prev[b]) pidx = b;
                check($sformatf("vec%0d_mem_addr", n), 32'(mem_addr), 32'(16'h0100 + pidx));
                check($sformatf("vec%0d_mem_wdata", n), 32'(mem_wdata), 32'(16'hA000 + pidx));
            end
            check($sformatf("vec%0d_rvalid", n), 32'(rvalid), 32'h0);
            prev = vecs[n].exp_gnt;
            tick();
        end

        // Back-to-back reads: req1 at addr 5, then req0 at addr 9.
        we = 4'b0000; set_addr(1, 16'h0005); set_addr(0, 16'h0009);
        req = 4'b0010;
        #1 check("rd_gnt1", 32'(gnt), 32'h2);
        tick();
        req = 4'b0001;
        #1 check("rd_gnt0", 32'(gnt), 32'h1);
        check("rd_mem_en", 32'(mem_en), 32'h1);
        check("rd_mem_addr5", 32'(mem_addr), 32'h5);
        tick();
        req = 4'b0000;
        #1 check("rd_rvalid_early", 32'(rvalid), 32'h0);
        check("rd_mem_addr9", 32'(mem_addr), 32'h9);
        tick();
        check("rd_rvalid1", 32'(rvalid), 32'h2);
        check("rd_rdata1", 32'(rdata), 32'(16'h0005 ^ 16'hBEEF));
        tick();
        check("rd_rvalid0", 32'(rvalid), 32'h1);
        check("rd_rdata0", 32'(rdata), 32'(16'h0009 ^ 16'hBEEF));
        tick();
        check("rd_rvalid_done", 32'(rvalid), 32'h0);
        check("rd_rdata_done", 32'(rdata), 32'h0);

        // Mode switch 1->0 in the middle of owner 1's burst.
        mode = 1'b1; req = 4'b0010;
        #1 check("sw_gnt_a", 32'(gnt), 32'h2);
        tick();
        req = 4'b1010;
        #1 check("sw_gnt_b", 32'(gnt), 32'h2);
        tick();
        mode = 1'b0; force_sel = 2'd3;
        #1 check("sw_forced_gnt", 32'(gnt), 32'h8);
        tick();
        #1 check("sw_forced_gnt2", 32'(gnt), 32'h8);
        tick();
        req = 4'b0010;
        #1 check("sw_no_spurious", 32'(gnt), 32'h0);
        tick();

        // Reset with two reads in flight.
        mode = 1'b1; req = 4'b0001; we = 4'b0000;
        #1 check("rr_gnt_a", 32'(gnt), 32'h1);
        tick();
        #1 check("rr_gnt_b", 32'(gnt), 32'h1);
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_gnt", 32'(gnt), 32'h0);
        check("mid_rst_rvalid", 32'(rvalid), 32'h0);
        check("mid_rst_mem_en", 32'(mem_en), 32'h0);
        check("mid_rst_mem_addr", 32'(mem_addr), 32'h0);
        check("mid_rst_rdata", 32'(rdata), 32'h0);
        #1;
        rst = 1'b0; req = 4'b0000;
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("post_rst_rvalid%0d", c), 32'(rvalid), 32'h0);
            check($sformatf("post_rst_mem_en%0d", c), 32'(mem_en), 32'h0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
